// File: rtl/hpc3_share_encoder.sv
// Splits operands a/b into three Boolean shares and supplies fresh gadget randomness
// for a 3-share HPC3 masked AND, all drawn from a ten-word pool refilled by a Galois LFSR.
module hpc3_share_encoder #(
   parameter int                WIDTH        = 8,
   parameter int                LFSR_W       = 32,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = 32'hACE1_2468
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              seed_load_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  b_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [WIDTH-1:0]  a0_o,
   output logic [WIDTH-1:0]  a1_o,
   output logic [WIDTH-1:0]  a2_o,
   output logic [WIDTH-1:0]  b0_o,
   output logic [WIDTH-1:0]  b1_o,
   output logic [WIDTH-1:0]  b2_o,
   output logic [WIDTH-1:0]  r01_o,
   output logic [WIDTH-1:0]  r02_o,
   output logic [WIDTH-1:0]  r12_o,
   output logic [WIDTH-1:0]  p01_o,
   output logic [WIDTH-1:0]  p02_o,
   output logic [WIDTH-1:0]  p12_o
);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      READY = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int                POOL_N = 10;
   localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(32'h8020_0003);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsrNext;
   logic [WIDTH-1:0]  pool_q [POOL_N];
   logic              fillEn, acceptEn;

   logic [WIDTH-1:0]  a0_q, a1_q, a2_q, b0_q, b1_q, b2_q;
   logic [WIDTH-1:0]  r01_q, r02_q, r12_q, p01_q, p02_q, p12_q;

   // Right-shifting Galois form of x^32+x^22+x^2+x+1, unrolled WIDTH steps.
   function automatic logic [LFSR_W-1:0] lfsrAdvance(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] v;
      v = s;
      for (int i = 0; i < WIDTH; i++) begin
         v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
      end
      return v;
   endfunction

   assign lfsrNext = lfsrAdvance(lfsr_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lfsr_d     = lfsr_q;
      fillEn     = 1'b0;
      acceptEn   = 1'b0;
      in_ready_o = 1'b0;
      // A seed load overrides everything, so in_ready is never raised alongside it.
      if (seed_load_i) begin
         lfsr_d  = (seed_i == '0) ? DEFAULT_SEED : seed_i;
         state_d = FILL;
         cnt_d   = 4'd0;
      end else begin
         unique case (state_q)
            FILL: begin
               fillEn = 1'b1;
               lfsr_d = lfsrNext;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == 4'(POOL_N - 1)) begin
                  state_d = READY;
                  cnt_d   = 4'd0;
               end
            end
            READY: begin
               in_ready_o = 1'b1;
               if (in_valid_i) begin
                  acceptEn = 1'b1;
                  state_d  = HOLD;
               end
            end
            HOLD: begin
               if (out_ready_i) begin
                  state_d = FILL;
                  cnt_d   = 4'd0;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FILL;
         cnt_q   <= 4'd0;
         lfsr_q  <= DEFAULT_SEED;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < POOL_N; i++) pool_q[i] <= '0;
      end else if (fillEn) begin
         pool_q[cnt_q] <= lfsrNext[WIDTH-1:0];
      end
   end

   // The bundle registers only change on acceptance and otherwise keep their last value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a0_q  <= '0;  a1_q  <= '0;  a2_q  <= '0;
         b0_q  <= '0;  b1_q  <= '0;  b2_q  <= '0;
         r01_q <= '0;  r02_q <= '0;  r12_q <= '0;
         p01_q <= '0;  p02_q <= '0;  p12_q <= '0;
      end else if (acceptEn) begin
         a0_q  <= a_i ^ pool_q[0] ^ pool_q[1];
         a1_q  <= pool_q[0];
         a2_q  <= pool_q[1];
         b0_q  <= b_i ^ pool_q[2] ^ pool_q[3];
         b1_q  <= pool_q[2];
         b2_q  <= pool_q[3];
         r01_q <= pool_q[4];
         r02_q <= pool_q[5];
         r12_q <= pool_q[6];
         p01_q <= pool_q[7];
         p02_q <= pool_q[8];
         p12_q <= pool_q[9];
      end
   end

   assign out_valid_o = (state_q == HOLD);
   assign a0_o  = a0_q;
   assign a1_o  = a1_q;
   assign a2_o  = a2_q;
   assign b0_o  = b0_q;
   assign b1_o  = b1_q;
   assign b2_o  = b2_q;
   assign r01_o = r01_q;
   assign r02_o = r02_q;
   assign r12_o = r12_q;
   assign p01_o = p01_q;
   assign p02_o = p02_q;
   assign p12_o = p12_q;

endmodule

// File: tb/tb_hpc3_share_encoder.sv
// Self-checking bench for hpc3_share_encoder: reset timing, share encoding against an
// LFSR reference model, backpressure, seed loading, mid-HOLD reset and a random sweep.
module tb_hpc3_share_encoder;

   localparam int          WIDTH        = 8;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

   logic              clk = 1'b0;
   logic              rst;
   logic              seedLoad;
   logic [31:0]       seed;
   logic              inValid, inReady;
   logic [WIDTH-1:0]  a, b;
   logic              outValid, outReady;
   logic [WIDTH-1:0]  a0, a1, a2, b0, b1, b2, r01, r02, r12, p01, p02, p12;

   int                checks   = 0;
   int                failures = 0;
   logic [31:0]       mLfsr;
   logic [WIDTH-1:0]  mPool [10];
   logic [95:0]       snap;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] expAnd;
      int               hold;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   hpc3_share_encoder #(.WIDTH(WIDTH), .LFSR_W(32), .DEFAULT_SEED(DEFAULT_SEED)) dut (
      .clk_i(clk), .rst_i(rst), .seed_load_i(seedLoad), .seed_i(seed),
      .in_valid_i(inValid), .in_ready_o(inReady), .a_i(a), .b_i(b),
      .out_valid_o(outValid), .out_ready_i(outReady),
      .a0_o(a0), .a1_o(a1), .a2_o(a2), .b0_o(b0), .b1_o(b1), .b2_o(b2),
      .r01_o(r01), .r02_o(r02), .r12_o(r12), .p01_o(p01), .p02_o(p02), .p12_o(p12)
   );

   // Reference Galois LFSR (x^32+x^22+x^2+x+1), eight single-bit steps per pool word.
   function automatic logic [31:0] modelStep8(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < 8; i++) begin
         if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
         else      v = v >> 1;
      end
      return v;
   endfunction

   function automatic logic [95:0] allOut();
      return {a0, a1, a2, b0, b1, b2, r01, r02, r12, p01, p02, p12};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic modelFill();
      for (int i = 0; i < 10; i++) begin
         mLfsr    = modelStep8(mLfsr);
         mPool[i] = mLfsr[WIDTH-1:0];
      end
   endtask

   // Waits (bounded) for in_ready; exp >= 0 also checks the number of cycles waited.
   task automatic waitReady(input int exp);
      int n;
      n = 0;
      while (!inReady && n < 50) begin
         tick();
         n++;
      end
      checkOutput("ready_wait", inReady, 1);
      if (exp >= 0) checkOutput("ready_latency", n, exp);
   endtask

   task automatic handshake(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic [WIDTH-1:0] expAnd);
      modelFill();
      a       = ta;
      b       = tb;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
      checkOutput("out_valid_latency", outValid, 1);
      checkOutput("in_ready_in_hold", inReady, 0);
      checkOutput("a0", a0, ta ^ mPool[0] ^ mPool[1]);
      checkOutput("a1", a1, mPool[0]);
      checkOutput("a2", a2, mPool[1]);
      checkOutput("b0", b0, tb ^ mPool[2] ^ mPool[3]);
      checkOutput("b1", b1, mPool[2]);
      checkOutput("b2", b2, mPool[3]);
      checkOutput("r_words", {r01, r02, r12}, {mPool[4], mPool[5], mPool[6]});
      checkOutput("p_words", {p01, p02, p12}, {mPool[7], mPool[8], mPool[9]});
      checkOutput("a_reconstruct", a0 ^ a1 ^ a2, ta);
      checkOutput("b_reconstruct", b0 ^ b1 ^ b2, tb);
      checkOutput("and_reconstruct", (a0 ^ a1 ^ a2) & (b0 ^ b1 ^ b2), expAnd);
      snap = allOut();
   endtask

   task automatic holdAndRelease(input int hold);
      outReady = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput("hold_valid", outValid, 1);
         checkOutput("hold_in_ready", inReady, 0);
         checkOutput("hold_stable", allOut(), snap);
      end
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
      checkOutput("release_valid_drop", outValid, 0);
      checkOutput("release_in_ready", inReady, 0);
   endtask

   task automatic applyStimulus(input vec_t v);
      waitReady(-1);
      handshake(v.a, v.b, v.expAnd);
      holdAndRelease(v.hold);
      waitReady(10);
   endtask

   initial begin
      vecs[0] = '{a: 8'hA5, b: 8'h3C, expAnd: 8'h24, hold: 0};
      vecs[1] = '{a: 8'hFF, b: 8'h00, expAnd: 8'h00, hold: 5};
      vecs[2] = '{a: 8'h00, b: 8'hFF, expAnd: 8'h00, hold: 1};
      vecs[3] = '{a: 8'hFF, b: 8'hFF, expAnd: 8'hFF, hold: 2};
      vecs[4] = '{a: 8'h5A, b: 8'hC3, expAnd: 8'h42, hold: 0};
      vecs[5] = '{a: 8'h81, b: 8'h7E, expAnd: 8'h00, hold: 3};
      vecs[6] = '{a: 8'hF0, b: 8'h3C, expAnd: 8'h30, hold: 0};
      vecs[7] = '{a: 8'h12, b: 8'h34, expAnd: 8'h10, hold: 4};

      rst      = 1'b1;
      seedLoad = 1'b0;
      seed     = '0;
      inValid  = 1'b0;
      outReady = 1'b0;
      a        = '0;
      b        = '0;
      mLfsr    = DEFAULT_SEED;
      repeat (3) tick();
      checkOutput("reset_outputs", allOut(), 0);
      checkOutput("reset_in_ready", inReady, 0);
      checkOutput("reset_out_valid", outValid, 0);

      // in_ready must stay low for exactly ten fill cycles after release.
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checkOutput("fill_in_ready", inReady, 0);
         checkOutput("fill_outputs_zero", allOut(), 0);
         tick();
      end
      checkOutput("ready_after_fill", inReady, 1);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Seed load of zero during HOLD discards the bundle and restarts from DEFAULT_SEED.
      handshake(8'hC3, 8'h99, 8'h81);
      seedLoad = 1'b1;
      seed     = 32'h0;
      tick();
      seedLoad = 1'b0;
      checkOutput("seed0_valid_drop", outValid, 0);
      checkOutput("seed0_outputs_kept", allOut(), snap);
      mLfsr = DEFAULT_SEED;
      waitReady(10);
      handshake(8'hA5, 8'h3C, 8'h24);
      holdAndRelease(0);
      waitReady(10);

      // Seed load of 1 in READY with a simultaneous in_valid: no acceptance.
      seedLoad = 1'b1;
      seed     = 32'h1;
      inValid  = 1'b1;
      a        = 8'h77;
      b        = 8'h11;
      #1;
      checkOutput("seed_blocks_in_ready", inReady, 0);
      tick();
      seedLoad = 1'b0;
      inValid  = 1'b0;
      checkOutput("seed_no_accept", outValid, 0);
      mLfsr = 32'h1;
      waitReady(10);
      handshake(8'h6B, 8'hD2, 8'h42);
      holdAndRelease(1);
      waitReady(10);

      // Reset during HOLD returns everything to reset values at once.
      handshake(8'h0F, 8'hF0, 8'h00);
      rst = 1'b1;
      #1;
      checkOutput("midhold_reset_outputs", allOut(), 0);
      checkOutput("midhold_reset_valid", outValid, 0);
      checkOutput("midhold_reset_ready", inReady, 0);
      tick();
      rst   = 1'b0;
      mLfsr = DEFAULT_SEED;
      waitReady(10);

      for (int i = 0; i < 200; i++) begin
         logic [WIDTH-1:0] ra, rb;
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         handshake(ra, rb, ra & rb);
         holdAndRelease(0);
         waitReady(10);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
